sram_byte_bridge: RTL and testbench

//  Bus slave downstream of the maxicore32 bus interface. Converts one 32-bit word-addressed

---
 rtl/sram_byte_bridge.sv | 250 +++++++++++++++++++++++++
 tb/tb_sram_byte_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_byte_bridge.sv
// Bridges one 32-bit word bus cycle onto an 8-bit asynchronous SRAM.
// Each enabled byte lane runs SETUP, STROBE (WAIT_STATES+1) and HOLD.
module sram_byte_bridge #(
  parameter int WAIT_STATES     = 2,
  parameter int SRAM_ADDR_WIDTH = 19
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [29:0]                bus_address,
  input  logic [31:0]                bus_data_out,
  input  logic [3:0]                 bus_data_strobes,
  input  logic                       bus_read,
  input  logic                       bus_write,
  input  logic                       bus_select,
  output logic [31:0]                bus_data_in,
  output logic                       bus_wait,
  output logic                       protocol_error,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
  output logic [7:0]                 sram_data_out,
  input  logic [7:0]                 sram_data_in,
  output logic                       sram_data_oe,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);

  localparam int AW = SRAM_ADDR_WIDTH - 2;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // First enabled lane at offset >= from; bit 2 set means none left.
  // Strobe bit 3 is offset 0 (big-endian lane order).
  function automatic logic [2:0] find_lane(
    input logic [3:0] s,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'b100;
    for (int k = 3; k >= 0; k--) begin
      if (k >= int'(from) && s[3-k]) r = {1'b0, 2'(k)};
    end
    return r;
  endfunction

  function automatic logic [7:0] get_byte(
    input logic [31:0] w,
    input logic [1:0]  o
  );
    logic [7:0] r;
    case (o)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    case (o)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  logic [2:0]                 state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 strb_q, strb_d;
  logic                       rd_q, rd_d;
  logic [1:0]                 lane_q, lane_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [31:0]                rbuf_q, rbuf_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       perr_q, perr_d;
  logic [SRAM_ADDR_WIDTH-1:0] sa_q, sa_d;
  logic [7:0]                 sdo_q, sdo_d;
  logic                       doe_q, doe_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;

  logic       req;
  logic [2:0] first;
  logic [2:0] nxt;

  // Upper bus address bits alias onto the SRAM and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^bus_address[29:AW];

  assign req   = bus_select & (bus_read ^ bus_write);
  assign first = find_lane(bus_data_strobes, 3'd0);
  assign nxt   = find_lane(strb_q, {1'b0, lane_q} + 3'd1);

  // Stall the core from request acceptance until DONE.
  always_comb begin
    bus_wait = reset & (((state_q == IDLE) & req) |
                        (state_q == SETUP) |
                        (state_q == STROBE) |
                        (state_q == HOLD));
  end

  assign bus_data_in    = rdata_q;
  assign protocol_error = perr_q;
  assign sram_address   = sa_q;
  assign sram_data_out  = sdo_q;
  assign sram_data_oe   = doe_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_we_n      = we_n_q;

  // Sequencer: walks enabled lanes and computes registered SRAM pins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rd_d    = rd_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    perr_d  = 1'b0;
    sa_d    = sa_q;
    sdo_d   = sdo_q;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus_address[AW-1:0];
          wdata_d = bus_data_out;
          strb_d  = bus_data_strobes;
          rd_d    = bus_read;
          rbuf_d  = 32'h0;
          if (!first[2]) begin
            state_d = SETUP;
            lane_d  = first[1:0];
            sa_d    = {bus_address[AW-1:0], first[1:0]};
            ce_n_d  = 1'b0;
            if (bus_write) begin
              doe_d = 1'b1;
              sdo_d = get_byte(bus_data_out, first[1:0]);
            end
          end else begin
            state_d = DONE;
            if (bus_read) rdata_d = 32'h0;
          end
        end else if (bus_select & bus_read & bus_write) begin
          perr_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CW'(WAIT_STATES);
        if (rd_q) oe_n_d = 1'b0;
        else      we_n_d = 1'b0;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (rd_q) rbuf_d = put_byte(rbuf_q, lane_q, sram_data_in);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (!nxt[2]) begin
          state_d = SETUP;
          lane_d  = nxt[1:0];
          sa_d    = {addr_q, nxt[1:0]};
          if (!rd_q) sdo_d = get_byte(wdata_q, nxt[1:0]);
        end else begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          doe_d   = 1'b0;
          if (rd_q) rdata_d = rbuf_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        doe_d   = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset aborts any cycle in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      rd_q    <= 1'b0;
      lane_q  <= 2'd0;
      cnt_q   <= '0;
      rbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      perr_q  <= 1'b0;
      sa_q    <= '0;
      sdo_q   <= 8'h0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rd_q    <= rd_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
      sa_q    <= sa_d;
      sdo_q   <= sdo_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed bench for sram_byte_bridge with a behavioural byte SRAM.
// Strobe activity is logged per access and compared to hand values.
module tb_sram_byte_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] bus_address = '0;
  logic [31:0] bus_data_out = '0;
  logic [3:0]  bus_data_strobes = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_select = 1'b0;
  logic [31:0] bus_data_in;
  logic        bus_wait;
  logic        protocol_error;
  logic [18:0] sram_address;
  logic [7:0]  sram_data_out;
  logic [7:0]  sram_data_in;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sram_byte_bridge #(
    .WAIT_STATES    (2),
    .SRAM_ADDR_WIDTH(19)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus_address     (bus_address),
    .bus_data_out    (bus_data_out),
    .bus_data_strobes(bus_data_strobes),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_select      (bus_select),
    .bus_data_in     (bus_data_in),
    .bus_wait        (bus_wait),
    .protocol_error  (protocol_error),
    .sram_address    (sram_address),
    .sram_data_out   (sram_data_out),
    .sram_data_in    (sram_data_in),
    .sram_data_oe    (sram_data_oe),
    .sram_ce_n       (sram_ce_n),
    .sram_oe_n       (sram_oe_n),
    .sram_we_n       (sram_we_n)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;
  int ce_cycles = 0;
  int we_run = 0;
  int oe_run = 0;
  int wa[$];
  int wd[$];
  int wr[$];
  int ra[$];
  int rr[$];

  assign sram_data_in = (!sram_ce_n && !sram_oe_n) ?
                        mem[sram_address[7:0]] : 8'h00;

  // SRAM model and strobe logger, sampling the cycle just ending.
  always @(posedge clock) begin
    if (!sram_ce_n) ce_cycles = ce_cycles + 1;
    if (!sram_we_n) begin
      if (we_run == 0) begin
        wa.push_back(int'(sram_address));
        wd.push_back(int'(sram_data_out));
      end
      we_run = we_run + 1;
      if (!sram_ce_n && sram_data_oe)
        mem[sram_address[7:0]] = sram_data_out;
    end else if (we_run != 0) begin
      wr.push_back(we_run);
      we_run = 0;
    end
    if (!sram_oe_n) begin
      if (oe_run == 0) ra.push_back(int'(sram_address));
      oe_run = oe_run + 1;
    end else if (oe_run != 0) begin
      rr.push_back(oe_run);
      oe_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    wr.delete();
    ra.delete();
    rr.delete();
  endtask

  task automatic idle_bus();
    bus_select       = 1'b0;
    bus_read         = 1'b0;
    bus_write        = 1'b0;
    bus_data_strobes = 4'h0;
    bus_data_out     = 32'h0;
    bus_address      = '0;
  endtask

  // One full bus cycle; wc counts stalled clocks after acceptance.
  task automatic bus_cycle(input logic rd, input logic wrt,
                           input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string tag,
                           output int wc, output logic [31:0] rdata);
    bit done;
    @(negedge clock);
    bus_select       = 1'b1;
    bus_read         = rd;
    bus_write        = wrt;
    bus_address      = a;
    bus_data_out     = d;
    bus_data_strobes = s;
    #1;
    check({tag, " req_wait"}, {31'b0, bus_wait}, 32'd1);
    wc   = 0;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      if (bus_wait) wc++;
      else done = 1'b1;
    end
    check({tag, " finished"}, {31'b0, done}, 32'd1);
    rdata = bus_data_in;
    check({tag, " done_ce_n"}, {31'b0, sram_ce_n}, 32'd1);
    check({tag, " done_oe"}, {31'b0, sram_data_oe}, 32'd0);
    idle_bus();
  endtask

  initial begin
    int wc;
    int ce0;
    logic [31:0] rd;
    logic [31:0] exp_w;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset held with a live request on the bus.
    reset            = 1'b0;
    bus_select       = 1'b1;
    bus_read         = 1'b1;
    bus_data_strobes = 4'hF;
    bus_address      = 30'h10;
    repeat (3) @(negedge clock);
    check("rst bus_wait", {31'b0, bus_wait}, 32'd0);
    check("rst ce_n", {31'b0, sram_ce_n}, 32'd1);
    check("rst oe_n", {31'b0, sram_oe_n}, 32'd1);
    check("rst we_n", {31'b0, sram_we_n}, 32'd1);
    check("rst data_oe", {31'b0, sram_data_oe}, 32'd0);
    check("rst addr", {13'b0, sram_address}, 32'd0);
    check("rst dout", {24'b0, sram_data_out}, 32'd0);
    check("rst rdata", bus_data_in, 32'd0);
    check("rst perr", {31'b0, protocol_error}, 32'd0);
    idle_bus();
    reset = 1'b1;
    @(negedge clock);

    // Full-word write, four lanes.
    clear_logs();
    bus_cycle(1'b0, 1'b1, 30'h10, 32'h11223344, 4'hF, "wr4", wc, rd);
    check("wr4 wait", wc, 32'd20);
    check("wr4 count", wa.size(), 32'd4);
    exp_w = 32'h11223344;
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check($sformatf("wr4 addr%0d", i), wa[i], 32'h40 + i);
      check($sformatf("wr4 data%0d", i), wd[i],
            {24'b0, exp_w[31:24]});
      check($sformatf("wr4 we_len%0d", i), wr[i], 32'd3);
      exp_w = exp_w << 8;
    end

    // Full-word read.
    mem[8'h40] = 8'hAA;
    mem[8'h41] = 8'hBB;
    mem[8'h42] = 8'hCC;
    mem[8'h43] = 8'hDD;
    clear_logs();
    bus_cycle(1'b1, 1'b0, 30'h10, 32'h0, 4'hF, "rd4", wc, rd);
    check("rd4 data", rd, 32'hAABBCCDD);
    check("rd4 wait", wc, 32'd20);
    check("rd4 count", ra.size(), 32'd4);
    check("rd4 no_we", wa.size(), 32'd0);
    for (int i = 0; i < 4 && i < ra.size(); i++) begin
      check($sformatf("rd4 addr%0d", i), ra[i], 32'h40 + i);
      check($sformatf("rd4 oe_len%0d", i), rr[i], 32'd3);
    end
    repeat (3) @(negedge clock);
    check("rd4 hold", bus_data_in, 32'hAABBCCDD);

    // Single byte write at offset 2.
    clear_logs();
    bus_cycle(1'b0, 1'b1, 30'h10, 32'h0000AB00, 4'b0010, "wr1", wc, rd);
    check("wr1 wait", wc, 32'd5);
    check("wr1 count", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      check("wr1 addr", wa[0], 32'h42);
      check("wr1 data", wd[0], 32'hAB);
      check("wr1 we_len", wr[0], 32'd3);
    end

    // Sparse read: offsets 0 and 3, middle lanes return zero.
    clear_logs();
    bus_cycle(1'b1, 1'b0, 30'h10, 32'h0, 4'b1001, "rd2", wc, rd);
    check("rd2 data", rd, 32'hAA0000DD);
    check("rd2 wait", wc, 32'd10);
    check("rd2 count", ra.size(), 32'd2);

    // No lanes enabled: straight to DONE with no SRAM activity.
    ce0 = ce_cycles;
    bus_cycle(1'b1, 1'b0, 30'h10, 32'h0, 4'b0000, "rd0", wc, rd);
    check("rd0 data", rd, 32'h0);
    check("rd0 wait", wc, 32'd0);
    check("rd0 no_ce", ce_cycles, ce0);

    // Address bits above the SRAM range alias.
    clear_logs();
    bus_cycle(1'b0, 1'b1, 30'h20010, 32'h5A000000, 4'b1000, "alias",
              wc, rd);
    check("alias wait", wc, 32'd5);
    check("alias count", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      check("alias addr", wa[0], 32'h40);
      check("alias data", wd[0], 32'h5A);
    end

    // Read and write together.
    ce0 = ce_cycles;
    @(negedge clock);
    bus_select       = 1'b1;
    bus_read         = 1'b1;
    bus_write        = 1'b1;
    bus_address      = 30'h10;
    bus_data_strobes = 4'hF;
    #1;
    check("perr wait", {31'b0, bus_wait}, 32'd0);
    @(negedge clock);
    check("perr pulse", {31'b0, protocol_error}, 32'd1);
    check("perr wait2", {31'b0, bus_wait}, 32'd0);
    idle_bus();
    @(negedge clock);
    check("perr clear", {31'b0, protocol_error}, 32'd0);
    check("perr no_ce", ce_cycles, ce0);

    // Reset while lane 2 of a write is in SETUP.
    clear_logs();
    @(negedge clock);
    bus_select       = 1'b1;
    bus_write        = 1'b1;
    bus_address      = 30'h10;
    bus_data_out     = 32'h01020304;
    bus_data_strobes = 4'hF;
    for (int i = 0; i < 11; i++) @(negedge clock);
    check("abort at_lane2", {13'b0, sram_address}, 32'h42);
    check("abort at_ce", {31'b0, sram_ce_n}, 32'd0);
    reset = 1'b0;
    idle_bus();
    @(negedge clock);
    check("abort ce_n", {31'b0, sram_ce_n}, 32'd1);
    check("abort we_n", {31'b0, sram_we_n}, 32'd1);
    check("abort oe_n", {31'b0, sram_oe_n}, 32'd1);
    check("abort data_oe", {31'b0, sram_data_oe}, 32'd0);
    check("abort wait", {31'b0, bus_wait}, 32'd0);
    check("abort count", wa.size(), 32'd2);
    reset = 1'b1;
    clear_logs();
    bus_cycle(1'b1, 1'b0, 30'h10, 32'h0, 4'hF, "post", wc, rd);
    check("post data", rd, 32'h0102ABDD);
    check("post wait", wc, 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
